// File: rtl/rx_os_lane_tracker.sv
// rx_os_lane_tracker
// Receive-side ordered-set qualifier for the Rx LTSSM path. For each active
// lane it counts consecutive identical TS1/TS2 ordered sets that carry the
// expected identifier and link number. The run ends with success once every
// active lane reaches its target count. It can also end on a timeout, or on
// electrical idle seen for two consecutive cycles. The cause is reported in
// exit_code.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   start            one-cycle pulse; clears and arms a run (also restarts)
//   os_data/os_valid per-lane 128-bit ordered set and its valid strobe
//   num_lanes        active lane count (clamped to 1..LANES at start)
//   os_type          0 = TS1 (sym6 8'h4A), 1 = TS2 (sym6 8'h45)
//   link_num/link_any expected sym1, or wildcard
//   target           consecutive count each lane must reach
//   timeout_cyc      run length limit in cycles, 0 = unlimited
//   idle_abort/rx_elec_idle electrical-idle exit enable and input
//   busy, finish     run in progress, end-of-run pulse
//   exit_code        0 success, 1 timeout, 2 electrical idle
//   lane_ok          per-lane target reached
//   rate_id, upcfg   sym4 and sym4[6] of the last qualifying OS on lane 0
module rx_os_lane_tracker #(
  parameter int LANES = 16,
  parameter int CNTW  = 5,
  parameter int TMRW  = 24,
  parameter int LW    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LANES*128-1:0]  os_data,
  input  logic [LANES-1:0]      os_valid,
  input  logic [LW-1:0]         num_lanes,
  input  logic                  os_type,
  input  logic [7:0]            link_num,
  input  logic                  link_any,
  input  logic [CNTW-1:0]       target,
  input  logic [TMRW-1:0]       timeout_cyc,
  input  logic                  idle_abort,
  input  logic                  rx_elec_idle,
  output logic                  busy,
  output logic                  finish,
  output logic [1:0]            exit_code,
  output logic [LANES-1:0]      lane_ok,
  output logic [7:0]            rate_id,
  output logic                  upcfg
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [LW-1:0]     nl_q;
  logic              type_q;
  logic [7:0]        link_q;
  logic              any_q;
  logic [CNTW-1:0]   tgt_q;
  logic [TMRW-1:0]   tmo_q;
  logic [TMRW-1:0]   timer;
  logic              idle_seen;
  logic [CNTW-1:0]   cnt  [LANES];
  logic [127:0]      prev [LANES];
  logic [LANES-1:0]  prev_v;

  logic [LW-1:0]     nl_clamp;
  logic [LANES-1:0]  active;
  logic [LANES-1:0]  match;
  logic [LANES-1:0]  same;
  logic [7:0]        exp_id;
  logic [CNTW-1:0]   tgt_eff;
  logic              all_ok;
  logic              idle_hit;
  logic              tmo_hit;

  // Lane count is clamped once at start so the active mask stays stable
  // for the whole run.
  always_comb begin
    nl_clamp = num_lanes;
    if (num_lanes == '0)
      nl_clamp = LW'(1);
    else if (num_lanes > LW'(LANES))
      nl_clamp = LW'(LANES);
  end

  // Per-lane qualification against the latched run configuration.
  always_comb begin
    exp_id = type_q ? 8'h45 : 8'h4A;
    for (int i = 0; i < LANES; i++) begin
      active[i] = (i < int'(nl_q));
      match[i]  = (os_data[i*128+48 +: 8] == exp_id) &&
                  (any_q || (os_data[i*128+8 +: 8] == link_q));
      same[i]   = prev_v[i] && (os_data[i*128 +: 128] == prev[i]);
    end
  end

  // A target of zero behaves like one so a lane still needs one OS.
  always_comb begin
    tgt_eff  = (tgt_q == '0) ? CNTW'(1) : tgt_q;
    all_ok   = &(lane_ok | ~active);
    idle_hit = idle_abort && rx_elec_idle && idle_seen;
    tmo_hit  = (tmo_q != '0) && (timer == tmo_q - 1'b1);
  end

  // Main controller. start has priority in every state, so a restart drops
  // the current run without a finish pulse. The exit checks use the
  // registered lane_ok, which gives success > idle > timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      finish    <= 1'b0;
      exit_code <= 2'd0;
      lane_ok   <= '0;
      rate_id   <= 8'h00;
      upcfg     <= 1'b0;
      nl_q      <= LW'(1);
      type_q    <= 1'b0;
      link_q    <= 8'h00;
      any_q     <= 1'b0;
      tgt_q     <= '0;
      tmo_q     <= '0;
      timer     <= '0;
      idle_seen <= 1'b0;
      prev_v    <= '0;
      for (int i = 0; i < LANES; i++) begin
        cnt[i]  <= '0;
        prev[i] <= '0;
      end
    end else if (start) begin
      state     <= RUN;
      busy      <= 1'b1;
      finish    <= 1'b0;
      exit_code <= 2'd0;
      lane_ok   <= '0;
      nl_q      <= nl_clamp;
      type_q    <= os_type;
      link_q    <= link_num;
      any_q     <= link_any;
      tgt_q     <= target;
      tmo_q     <= timeout_cyc;
      timer     <= '0;
      idle_seen <= 1'b0;
      prev_v    <= '0;
      for (int i = 0; i < LANES; i++) begin
        cnt[i]  <= '0;
        prev[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          finish <= 1'b0;
        end
        RUN: begin
          timer     <= timer + 1'b1;
          idle_seen <= idle_abort && rx_elec_idle;
          for (int i = 0; i < LANES; i++) begin
            if (active[i] && os_valid[i]) begin
              if (!match[i]) begin
                cnt[i]    <= '0;
                prev_v[i] <= 1'b0;
              end else if (same[i]) begin
                if (cnt[i] != '1)
                  cnt[i] <= cnt[i] + 1'b1;
              end else begin
                cnt[i]    <= CNTW'(1);
                prev[i]   <= os_data[i*128 +: 128];
                prev_v[i] <= 1'b1;
              end
            end
            lane_ok[i] <= active[i] && (cnt[i] >= tgt_eff);
          end
          if (os_valid[0] && match[0]) begin
            rate_id <= os_data[39:32];
            upcfg   <= os_data[38];
          end
          if (all_ok || idle_hit || tmo_hit) begin
            state  <= DONE;
            busy   <= 1'b0;
            finish <= 1'b1;
            if (all_ok)
              exit_code <= 2'd0;
            else if (idle_hit)
              exit_code <= 2'd2;
            else
              exit_code <= 2'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          finish <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          finish <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_os_lane_tracker.sv
// tb_rx_os_lane_tracker
// Directed bench for rx_os_lane_tracker with LANES = 16. Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
module tb_rx_os_lane_tracker;

  localparam int LANES = 16;
  localparam int CNTW  = 5;
  localparam int TMRW  = 24;
  localparam int LW    = 6;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [LANES*128-1:0] os_data;
  logic [LANES-1:0]     os_valid;
  logic [LW-1:0]        num_lanes;
  logic                 os_type;
  logic [7:0]           link_num;
  logic                 link_any;
  logic [CNTW-1:0]      target;
  logic [TMRW-1:0]      timeout_cyc;
  logic                 idle_abort;
  logic                 rx_elec_idle;
  logic                 busy;
  logic                 finish;
  logic [1:0]           exit_code;
  logic [LANES-1:0]     lane_ok;
  logic [7:0]           rate_id;
  logic                 upcfg;

  int vectors = 0;
  int miscompares = 0;

  rx_os_lane_tracker #(.LANES(LANES), .CNTW(CNTW), .TMRW(TMRW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .os_data(os_data),
    .os_valid(os_valid), .num_lanes(num_lanes), .os_type(os_type),
    .link_num(link_num), .link_any(link_any), .target(target),
    .timeout_cyc(timeout_cyc), .idle_abort(idle_abort),
    .rx_elec_idle(rx_elec_idle), .busy(busy), .finish(finish),
    .exit_code(exit_code), .lane_ok(lane_ok), .rate_id(rate_id),
    .upcfg(upcfg)
  );

  always #5 clk = ~clk;

  // Builds an ordered set: COM, link, rate in sym4, identifier in sym6,
  // every other byte filled with a tag.
  function automatic logic [127:0] mk_os(input logic [7:0] id, input logic [7:0] link,
                                         input logic [7:0] rate, input logic [7:0] tag);
    logic [127:0] v;
    v = {16{tag}};
    v[7:0]   = 8'hBC;
    v[15:8]  = link;
    v[39:32] = rate;
    v[55:48] = id;
    return v;
  endfunction

  task automatic set_lane(input int lane, input logic [127:0] os);
    os_data[lane*128 +: 128] = os;
  endtask

  task automatic applyStimulus(input logic [LANES-1:0] valid, input int cycles);
    os_valid = valid;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    applyStimulus('0, 1);
    start = 1'b0;
  endtask

  initial begin
    logic [LANES-1:0] v;
    reset = 1'b1; start = 1'b0; os_data = '0; os_valid = '0;
    num_lanes = 6'd4; os_type = 1'b0; link_num = 8'h05; link_any = 1'b0;
    target = 5'd8; timeout_cyc = '0; idle_abort = 1'b0; rx_elec_idle = 1'b0;
    applyStimulus('0, 2);
    reset = 1'b0;
    applyStimulus('0, 1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_finish", 64'(finish), 64'd0);
    checkOutput("rst_exit", 64'(exit_code), 64'd0);
    checkOutput("rst_lane_ok", 64'(lane_ok), 64'd0);
    checkOutput("rst_rate", 64'(rate_id), 64'd0);

    // 4 lanes TS1, lane 3 starts two cycles late.
    for (int i = 0; i < 4; i++)
      set_lane(i, mk_os(8'h4A, 8'h05, (i == 0) ? 8'h42 : 8'h10 + 8'(i), 8'h30 + 8'(i)));
    pulse_start();
    checkOutput("t1_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 10; k++) begin
      v = '0;
      if (k < 8) v[2:0] = 3'b111;
      if (k >= 2) v[3] = 1'b1;
      applyStimulus(v, 1);
    end
    checkOutput("t1_ok_partial", 64'(lane_ok), 64'h0007);
    applyStimulus('0, 1);
    checkOutput("t1_ok_all", 64'(lane_ok), 64'h000F);
    checkOutput("t1_no_finish", 64'(finish), 64'd0);
    applyStimulus('0, 1);
    checkOutput("t1_finish", 64'(finish), 64'd1);
    checkOutput("t1_exit", 64'(exit_code), 64'd0);
    checkOutput("t1_busy_end", 64'(busy), 64'd0);
    checkOutput("t1_rate", 64'(rate_id), 64'h42);
    checkOutput("t1_upcfg", 64'(upcfg), 64'd1);
    applyStimulus('0, 1);
    checkOutput("t1_finish_pulse", 64'(finish), 64'd0);
    checkOutput("t1_ok_hold", 64'(lane_ok), 64'h000F);

    // 2 lanes, lane 1 switches to a different matching OS after 5.
    num_lanes = 6'd2;
    set_lane(0, mk_os(8'h4A, 8'h05, 8'h02, 8'h50));
    pulse_start();
    for (int k = 0; k < 13; k++) begin
      set_lane(1, mk_os(8'h4A, 8'h05, 8'h02, (k < 5) ? 8'h61 : 8'h62));
      v = '0;
      v[0] = (k < 8);
      v[1] = 1'b1;
      applyStimulus(v, 1);
    end
    checkOutput("t2_ok_lane0", 64'(lane_ok), 64'h0001);
    checkOutput("t2_busy", 64'(busy), 64'd1);
    applyStimulus('0, 1);
    checkOutput("t2_ok_both", 64'(lane_ok), 64'h0003);
    applyStimulus('0, 1);
    checkOutput("t2_finish", 64'(finish), 64'd1);
    checkOutput("t2_exit", 64'(exit_code), 64'd0);
    checkOutput("t2_rate", 64'(rate_id), 64'h02);
    checkOutput("t2_upcfg", 64'(upcfg), 64'd0);
    applyStimulus('0, 1);

    // Wrong link number times out after exactly 100 cycles.
    num_lanes = 6'd4; timeout_cyc = 24'd100;
    for (int i = 0; i < 4; i++)
      set_lane(i, mk_os(8'h4A, 8'hF7, 8'h11, 8'h70 + 8'(i)));
    pulse_start();
    applyStimulus(16'h000F, 99);
    checkOutput("t3_pre_finish", 64'(finish), 64'd0);
    checkOutput("t3_pre_busy", 64'(busy), 64'd1);
    checkOutput("t3_no_ok", 64'(lane_ok), 64'd0);
    applyStimulus(16'h000F, 1);
    checkOutput("t3_finish", 64'(finish), 64'd1);
    checkOutput("t3_exit", 64'(exit_code), 64'd1);
    link_any = 1'b1;
    pulse_start();
    applyStimulus(16'h000F, 9);
    checkOutput("t3_any_ok", 64'(lane_ok), 64'h000F);
    checkOutput("t3_any_nofin", 64'(finish), 64'd0);
    applyStimulus(16'h000F, 1);
    checkOutput("t3_any_finish", 64'(finish), 64'd1);
    checkOutput("t3_any_exit", 64'(exit_code), 64'd0);
    link_any = 1'b0;
    applyStimulus('0, 1);

    // Electrical idle: one cycle ignored, two consecutive cycles exit.
    num_lanes = 6'd1; timeout_cyc = '0; idle_abort = 1'b1;
    set_lane(0, mk_os(8'h4A, 8'h05, 8'h21, 8'h80));
    pulse_start();
    rx_elec_idle = 1'b1;
    applyStimulus('0, 1);
    rx_elec_idle = 1'b0;
    applyStimulus('0, 2);
    checkOutput("t4_single_busy", 64'(busy), 64'd1);
    checkOutput("t4_single_fin", 64'(finish), 64'd0);
    rx_elec_idle = 1'b1;
    applyStimulus('0, 1);
    checkOutput("t4_first_fin", 64'(finish), 64'd0);
    applyStimulus('0, 1);
    checkOutput("t4_idle_finish", 64'(finish), 64'd1);
    checkOutput("t4_idle_exit", 64'(exit_code), 64'd2);
    rx_elec_idle = 1'b0;
    applyStimulus('0, 1);
    pulse_start();
    applyStimulus(16'h0001, 8);
    rx_elec_idle = 1'b1;
    applyStimulus(16'h0001, 1);
    checkOutput("t4_tie_nofin", 64'(finish), 64'd0);
    applyStimulus(16'h0001, 1);
    checkOutput("t4_tie_finish", 64'(finish), 64'd1);
    checkOutput("t4_tie_exit", 64'(exit_code), 64'd0);
    rx_elec_idle = 1'b0; idle_abort = 1'b0;
    applyStimulus('0, 1);

    // Restart mid-run, then reset mid-run.
    pulse_start();
    applyStimulus(16'h0001, 5);
    pulse_start();
    checkOutput("t5_restart_fin", 64'(finish), 64'd0);
    checkOutput("t5_restart_busy", 64'(busy), 64'd1);
    applyStimulus(16'h0001, 7);
    applyStimulus('0, 2);
    checkOutput("t5_cleared_ok", 64'(lane_ok), 64'd0);
    checkOutput("t5_cleared_fin", 64'(finish), 64'd0);
    checkOutput("t5_cleared_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    applyStimulus(16'h0001, 1);
    reset = 1'b0;
    checkOutput("t5_rst_busy", 64'(busy), 64'd0);
    checkOutput("t5_rst_fin", 64'(finish), 64'd0);
    checkOutput("t5_rst_exit", 64'(exit_code), 64'd0);
    checkOutput("t5_rst_ok", 64'(lane_ok), 64'd0);
    checkOutput("t5_rst_rate", 64'(rate_id), 64'd0);
    checkOutput("t5_rst_upcfg", 64'(upcfg), 64'd0);
    applyStimulus(16'h0001, 5);
    checkOutput("t5_idle_busy", 64'(busy), 64'd0);
    checkOutput("t5_idle_fin", 64'(finish), 64'd0);
    applyStimulus('0, 1);

    // num_lanes = 0 behaves as a single lane.
    num_lanes = 6'd0;
    pulse_start();
    checkOutput("t6_zero_nofin", 64'(finish), 64'd0);
    applyStimulus(16'h0001, 9);
    checkOutput("t6_zero_ok", 64'(lane_ok), 64'h0001);
    applyStimulus('0, 1);
    checkOutput("t6_zero_finish", 64'(finish), 64'd1);
    checkOutput("t6_zero_exit", 64'(exit_code), 64'd0);
    applyStimulus('0, 1);

    // num_lanes = 40 clamps to 16; counters saturate at 31.
    num_lanes = 6'd40; target = 5'd31;
    for (int i = 0; i < LANES; i++)
      set_lane(i, mk_os(8'h4A, 8'h05, 8'h33, 8'h90 + 8'(i)));
    pulse_start();
    applyStimulus(16'h7FFF, 40);
    checkOutput("t6_sat_ok", 64'(lane_ok), 64'h7FFF);
    checkOutput("t6_sat_busy", 64'(busy), 64'd1);
    applyStimulus(16'h8000, 31);
    applyStimulus('0, 1);
    checkOutput("t6_all_ok", 64'(lane_ok), 64'hFFFF);
    applyStimulus('0, 1);
    checkOutput("t6_all_finish", 64'(finish), 64'd1);
    checkOutput("t6_all_exit", 64'(exit_code), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_os_lane_tracker.md
Name: rx_os_lane_tracker

Overview:
- Parametrised receive-side ordered-set qualifier for the Rx LTSSM path.
- Per lane, counts consecutive identical TS1/TS2 ordered sets that match a programmed type and link number. Declares the substate exit condition once every active lane reaches its target count.
- Ends a run on success, timeout or electrical idle, and reports which one occurred.
- Generalises the fixed 16-lane checker with:
  - a LANES parameter;
  - a runtime target count;
  - a link-number wildcard mode;
  - an exit-cause code;
  - per-lane status;
  - a captured rate ID.

Parameters:
LANES, 16, number of lanes tracked (1..32)
CNTW, 5, width of per-lane consecutive counter (saturating)
TMRW, 24, width of timeout counter
LW, 6, width of num_lanes port (must hold LANES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; clears and arms a run
os_data  in  LANES*128  per-lane ordered set; lane i = bits [i*128+127:i*128]; symbol k = byte k
os_valid  in  LANES  per-lane ordered set valid
num_lanes  in  LW  active lanes; lanes 0..num_lanes-1 are tracked
os_type  in  1  0 = expect TS1 (sym6 = 8'h4A), 1 = expect TS2 (sym6 = 8'h45)
link_num  in  8  expected link number (sym1)
link_any  in  1  1 = sym1 not compared
target  in  CNTW  consecutive count required per lane
timeout_cyc  in  TMRW  cycles before timeout
idle_abort  in  1  enables electrical-idle exit
rx_elec_idle  in  1  receiver electrical idle
busy  out  1  run in progress
finish  out  1  one-cycle pulse at end of run
exit_code  out  2  0 = success, 1 = timeout, 2 = electrical idle; held until next start
lane_ok  out  LANES  per-lane target reached
rate_id  out  8  sym4 of the last qualifying OS on lane 0
upcfg  out  1  sym4 bit 6 of the same OS

Behaviour:
- Reset values:
  - state IDLE;
  - busy, finish, exit_code, lane_ok, rate_id, upcfg all 0;
  - all counters 0.
- States: IDLE, RUN, DONE.
  - IDLE + start -> RUN. Latch num_lanes, os_type, link_num, link_any, target and timeout_cyc. Clear counters, lane_ok and the previous-OS registers.
  - RUN -> DONE on success, timeout or idle, with exit_code set in the same cycle.
  - DONE -> IDLE after one cycle. finish = 1 during DONE only.
  - start in RUN or DONE restarts the run identically; no finish is produced for the abandoned run.
- busy = 1 in RUN.
- Qualification, active lane i in RUN, os_valid[i] = 1:
  - OS matches if sym6 equals the expected identifier, and either link_any = 1 or sym1 = link_num.
  - Match and identical to the previous matching OS on that lane (all 128 bits): count + 1, saturating at 2^CNTW-1.
  - Match but not identical, or first OS of the run: count = 1 and the OS is stored.
  - Non-match: count = 0 and the stored OS is invalidated.
  - os_valid[i] = 0: no change.
- Lane 0 qualifying OS: rate_id and upcfg update one cycle after it.
- lane_ok[i] = (count_i >= max(target,1)). Latency: one cycle from os_valid to the count update, one more cycle to lane_ok.
- Inactive lanes are ignored; their lane_ok stays 0.
- Clamping: num_lanes = 0 is treated as 1; num_lanes > LANES is treated as LANES.
- Success: every active lane has lane_ok = 1 in RUN.
- Timeout: timer counts up from 0 each RUN cycle; timeout when timer = timeout_cyc - 1. timeout_cyc = 0 means no timeout.
- Idle: idle_abort = 1 and rx_elec_idle = 1 for 2 consecutive RUN cycles.
- Priority within the same cycle: success > idle > timeout.
- IDLE/DONE: os_valid is ignored; lane_ok, rate_id and upcfg hold until the next start.
- Reset asserted mid-run: all state returns to reset values next edge; no finish is produced.

Test Plan:
- 4 lanes, TS1, link 8'h05, target 8: each lane receives 8 identical matching OS, with lane 3 two cycles late -> lane_ok = 4'hF, finish with exit_code 0 the cycle after lane 3 completes; rate_id = sym4 of lane 0.
- 2 lanes, target 8: lane 1 gets a differing OS after 5 -> lane 1 count restarts at 1; success only after 8 further identical OS.
- link_any = 0, sym1 = 8'hF7 on all lanes, timeout_cyc = 100 -> no count; finish with exit_code 1 exactly 100 cycles after start; link_any = 1 rerun succeeds.
- idle_abort = 1, rx_elec_idle high 1 cycle then 2 cycles -> no exit on the single cycle; exit_code 2 after the second; success arriving in the same cycle yields exit_code 0.
- start reissued mid-run, then reset mid-run -> counters cleared, no finish for the abandoned run; after reset all outputs are 0 and busy stays 0.
- num_lanes = 0 and num_lanes = 40 (LANES = 16) -> tracked as 1 and 16 lanes respectively; counter saturates at 31 with target 31.
